mux_scan_nch: RTL and testbench
===============================

// Module: mux_scan_nch
// PURPOSE
//   Parametrised N-channel, W-bit multiplexer with registered output and two modes.
//   MANUAL: select driven by the sel port. SCAN: an internal sequencer steps through the
//   channels enabled in ch_mask, dwelling DWELL cycles on each.
//   Next generation of the lab's 2:1/4:1/8:1 mux tree; feeds display and probe logic
//   that needs a time-multiplexed view of several buses.
// PARAMETERS
//   WIDTH    1   bits per channel (>=1)
//   CHANNELS 8   number of input channels (>=2, need not be a power of two)
//   DWELL    4   cycles spent on each enabled channel in SCAN mode (>=1)
//   SEL_W    localparam = $clog2(CHANNELS); width of every channel index
// PORTS
//   clk        in   1               rising-edge clock, the only clock
//   rst_n      in   1               asynchronous active-low reset
//   en         in   1               block enable; 0 forces IDLE
//   mode       in   1               0 = MANUAL, 1 = SCAN
//   sel        in   SEL_W           channel index, used in MANUAL only
//   ch_mask    in   CHANNELS        per-channel enable, used in SCAN only
//   din        in   CHANNELS*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
//   dout       out  WIDTH           registered selected data
//   dout_ch    out  SEL_W           index of the channel shown on dout
//   dout_valid out  1               dout/dout_ch are meaningful this cycle
//   wrap       out  1               one-cycle pulse when SCAN wraps to a lower or equal index
// BEHAVIOUR
//   Reset (async assert, sync release):
//     dout=0, dout_ch=0, dout_valid=0, wrap=0, state=IDLE, cur=0, dwell=0.
//   All outputs are registered. Latency is 1 cycle from din/sel to dout.
//   FSM states: IDLE, MANUAL, SCAN. Evaluated every cycle:
//     en=0 -> IDLE. en=1 & mode=0 -> MANUAL. en=1 & mode=1 -> SCAN.
//     Direct MANUAL<->SCAN switching is allowed, with no IDLE cycle in between.
//   IDLE:
//     dout_valid=0, wrap=0; dout/dout_ch hold their last values; dwell=0.
//   MANUAL:
//     sel<CHANNELS  -> dout<=din[sel], dout_ch<=sel, dout_valid<=1.
//     sel>=CHANNELS -> dout<=0, dout_ch<=sel, dout_valid<=0.
//   SCAN entry (from IDLE or MANUAL):
//     cur <= lowest set bit of ch_mask, dwell<=0, no wrap pulse.
//   SCAN steady state:
//     dout<=din[cur], dout_ch<=cur, dout_valid<=1.
//     dwell increments each cycle. At dwell==DWELL-1: dwell<=0, cur<=next enabled index
//     strictly above cur, circularly.
//     If that next index <= cur: wrap<=1 for one cycle. This includes a single enabled
//     channel, which wraps onto itself every DWELL cycles.
//   SCAN mask edge cases:
//     ch_mask==0        -> dout<=0, dout_valid<=0, cur and dwell frozen, wrap never fires.
//     ch_mask[cur]==0   -> advance to next enabled channel on this edge regardless of
//                          dwell; dwell<=0; wrap rules as above.
//     Mask becomes nonzero again -> treated as SCAN entry.
//   Simultaneous en fall and dwell expiry: IDLE wins; cur is not advanced, no wrap.
//   Async reset mid-dwell: all state cleared immediately.
//   No X propagation: unused sel/mask/din bits never reach dout.
// STRUCTURE
//   Shared include mux_defs.vh:
//     MODE_MANUAL/MODE_SCAN constants; ST_IDLE/ST_MANUAL/ST_SCAN encodings (2 bits).
//   Sub-module mux_next_ch:
//     combinational circular first-set-bit search.
//     In: mask[CHANNELS], cur[SEL_W]. Out: next[SEL_W], wrapped, none.
//     Reused for SCAN entry with cur = CHANNELS-1.
//   Top: FSM, dwell counter (width $clog2(DWELL+1)), cur register,
//        indexed part-select mux, output registers.
// TESTING
//   1. Reset: rst_n=0 asserted mid-cycle -> all outputs 0 without waiting for clk.
//   2. MANUAL, CHANNELS=8, WIDTH=4, din[k]=k+3:
//      sel=5 -> next cycle dout=8, dout_ch=5, valid=1.
//      CHANNELS=6, sel=7 -> dout=0, valid=0.
//   3. SCAN, DWELL=2, ch_mask=8'b1010_0100:
//      dout_ch sequence 2,2,5,5,7,7,2,...
//      wrap high exactly in the cycle dout_ch first shows 2 again.
//   4. SCAN with ch_mask[5] cleared while cur=5 at dwell 0:
//      next cycle cur=7, dwell restarts, no wrap.
//   5. ch_mask=0 in SCAN -> valid=0, dout=0, no wrap over 20 cycles.
//      Then mask=8'b0000_1000 -> cur=3 entry; wrap every 2 cycles thereafter.
//   6. en dropped on the dwell-expiry cycle -> IDLE, dout holds, valid=0, no wrap.
//      en re-asserted with mode=1 -> restart at lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_nch_pkg.sv
// Shared constants and FSM state type for the scanning N-channel multiplexer.
package mux_scan_nch_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_nch_next_ch.sv
// Combinational circular search for the next enabled channel strictly above cur.
// Passing cur = CHANNELS-1 yields the lowest enabled channel.
module mux_scan_nch_next_ch #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next_ch,
    output logic                wrapped,
    output logic                none
);

    logic             above_found;
    logic             low_found;
    logic [SEL_W-1:0] above_idx;
    logic [SEL_W-1:0] low_idx;

    // Two priority scans: first set bit above cur, and first set bit overall.
    always_comb begin
        above_found = 1'b0;
        low_found   = 1'b0;
        above_idx   = '0;
        low_idx     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mask[k] && !low_found) begin
                low_found = 1'b1;
                low_idx   = SEL_W'(k);
            end
            if (mask[k] && !above_found && (k > int'(cur))) begin
                above_found = 1'b1;
                above_idx   = SEL_W'(k);
            end
        end
        next_ch = above_found ? above_idx : low_idx;
        wrapped = low_found && !above_found;
        none    = !low_found;
    end

endmodule

// File: rtl/mux_scan_nch.sv
// N-channel, W-bit registered multiplexer with manual select and a dwell-timed
// scan sequencer over the channels enabled in ch_mask.
module mux_scan_nch
    import mux_scan_nch_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 8,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       ch_mask,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    output logic                      wrap
);

    localparam int               DW_W    = $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

    state_t           st_q, st_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             mask_seen_q, mask_seen_d;
    logic [WIDTH-1:0] dout_d;
    logic [SEL_W-1:0] dout_ch_d;
    logic             valid_d;
    logic             wrap_d;

    logic             entry;
    logic             mask_any;
    logic [SEL_W-1:0] search_cur;
    logic [SEL_W-1:0] nxt;
    logic             nxt_wrapped;
    logic             nxt_none;

    // Index guard keeps out-of-range selects from ever reaching dout.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) res = bus[k*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    mux_scan_nch_next_ch #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next_ch (
        .mask    (ch_mask),
        .cur     (search_cur),
        .next_ch (nxt),
        .wrapped (nxt_wrapped),
        .none    (nxt_none)
    );

    assign mask_any   = !nxt_none;
    assign search_cur = entry ? LAST_CH : cur_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            cur_q       <= '0;
            dwell_q     <= '0;
            mask_seen_q <= 1'b0;
            dout        <= '0;
            dout_ch     <= '0;
            dout_valid  <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            st_q        <= st_d;
            cur_q       <= cur_d;
            dwell_q     <= dwell_d;
            mask_seen_q <= mask_seen_d;
            dout        <= dout_d;
            dout_ch     <= dout_ch_d;
            dout_valid  <= valid_d;
            wrap        <= wrap_d;
        end
    end

    // Outputs track the channel the sequencer lands on this edge, so each channel
    // is visible for exactly DWELL cycles and wrap coincides with the revisit.
    always_comb begin
        st_d        = ST_IDLE;
        cur_d       = cur_q;
        dwell_d     = dwell_q;
        dout_d      = dout;
        dout_ch_d   = dout_ch;
        valid_d     = 1'b0;
        wrap_d      = 1'b0;
        entry       = 1'b0;

        if (en) st_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        mask_seen_d = (st_d == ST_SCAN) && mask_any;

        case (st_d)
            ST_IDLE: begin
                dwell_d = '0;
            end
            ST_MANUAL: begin
                dwell_d   = '0;
                dout_ch_d = sel;
                if (int'(sel) < CHANNELS) begin
                    dout_d  = pick(din, sel);
                    valid_d = 1'b1;
                end else begin
                    dout_d  = '0;
                end
            end
            ST_SCAN: begin
                entry = mask_any && ((st_q != ST_SCAN) || !mask_seen_q);
                if (!mask_any) begin
                    dout_d = '0;
                end else begin
                    valid_d = 1'b1;
                    if (entry) begin
                        cur_d   = nxt;
                        dwell_d = '0;
                    end else if (!ch_mask[cur_q] || (dwell_q == DW_LAST)) begin
                        cur_d   = nxt;
                        dwell_d = '0;
                        wrap_d  = nxt_wrapped;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                    dout_d    = pick(din, cur_d);
                    dout_ch_d = cur_d;
                end
            end
            default: begin
                dwell_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_nch.sv
// Randomized plus directed bench for mux_scan_nch against a cycle-level behavioural model.
module tb_mux_scan_nch;

    localparam int CH    = 8;
    localparam int W     = 4;
    localparam int DWELL = 2;
    localparam int SW    = 3;
    localparam int CH6   = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en, mode;
    logic [SW-1:0]     sel;
    logic [CH-1:0]     ch_mask;
    logic [CH*W-1:0]   din;
    logic [W-1:0]      dout;
    logic [SW-1:0]     dout_ch;
    logic              dout_valid, wrap;

    logic              en6, mode6;
    logic [2:0]        sel6;
    logic [CH6-1:0]    mask6;
    logic [CH6*W-1:0]  din6;
    logic [W-1:0]      dout6;
    logic [2:0]        dout_ch6;
    logic              valid6, wrap6;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    int         m_cur, m_left, m_ch, m6_ch;
    bit         m_run, m_valid, m_wrap, m6_valid;
    logic [W-1:0] m_dout, m6_dout;

    always #5 clk = ~clk;

    mux_scan_nch #(.WIDTH(W), .CHANNELS(CH), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .ch_mask(ch_mask),
        .din(din), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .wrap(wrap)
    );

    mux_scan_nch #(.WIDTH(W), .CHANNELS(CH6), .DWELL(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en6), .mode(mode6), .sel(sel6), .ch_mask(mask6),
        .din(din6), .dout(dout6), .dout_ch(dout_ch6), .dout_valid(valid6), .wrap(wrap6)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic [W-1:0] chanData(input int k);
        logic [CH*W-1:0] t;
        t = din >> (k * W);
        return t[W-1:0];
    endfunction

    function automatic bit maskBit(input logic [CH-1:0] m, input int j);
        logic [CH-1:0] t;
        t = m >> j;
        return t[0];
    endfunction

    function automatic int lowestSet(input logic [CH-1:0] m);
        for (int j = 0; j < CH; j++) if (maskBit(m, j)) return j;
        return 0;
    endfunction

    function automatic int nextAbove(input logic [CH-1:0] m, input int c);
        for (int i = 1; i <= CH; i++) if (maskBit(m, (c + i) % CH)) return (c + i) % CH;
        return c;
    endfunction

    task automatic modelReset();
        m_cur = 0; m_left = 0; m_ch = 0; m_run = 0; m_valid = 0; m_wrap = 0; m_dout = '0;
        m6_ch = 0; m6_valid = 0; m6_dout = '0;
    endtask

    task automatic modelStep();
        int n;
        logic [CH6*W-1:0] t6;
        m_wrap = 0;
        if (!en) begin
            m_valid = 0; m_run = 0;
        end else if (!mode) begin
            m_run = 0;
            m_ch  = int'(sel);
            if (int'(sel) < CH) begin m_dout = chanData(int'(sel)); m_valid = 1; end
            else begin m_dout = '0; m_valid = 0; end
        end else if (ch_mask == '0) begin
            m_dout = '0; m_valid = 0; m_run = 0;
        end else begin
            if (!m_run) begin
                m_cur = lowestSet(ch_mask); m_left = DWELL - 1; m_run = 1;
            end else if (!maskBit(ch_mask, m_cur) || m_left == 0) begin
                n = nextAbove(ch_mask, m_cur);
                m_wrap = (n <= m_cur);
                m_cur  = n; m_left = DWELL - 1;
            end else begin
                m_left--;
            end
            m_dout = chanData(m_cur); m_ch = m_cur; m_valid = 1;
        end
        m6_ch = int'(sel6);
        if (int'(sel6) < CH6) begin
            t6 = din6 >> (int'(sel6) * W);
            m6_dout = t6[W-1:0]; m6_valid = 1;
        end else begin
            m6_dout = '0; m6_valid = 0;
        end
    endtask

    task automatic compareAll();
        checkOutput("dout", dout, m_dout);
        checkOutput("dout_ch", dout_ch, m_ch);
        checkOutput("dout_valid", dout_valid, m_valid);
        checkOutput("wrap", wrap, m_wrap);
        checkOutput("dout6", dout6, m6_dout);
        checkOutput("dout_ch6", dout_ch6, m6_ch);
        checkOutput("valid6", valid6, m6_valid);
        checkOutput("wrap6", wrap6, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic applyStimulus(input logic e, input logic md, input logic [SW-1:0] s, input logic [CH-1:0] m);
        en = e; mode = md; sel = s; ch_mask = m;
        cycle();
    endtask

    initial begin
        int expCh[7] = '{2, 2, 5, 5, 7, 7, 2};
        int expWr[7] = '{0, 0, 0, 0, 0, 0, 1};
        int wr5[7]   = '{0, 0, 1, 0, 1, 0, 1};

        rst_n = 1'b0; en = 0; mode = 0; sel = '0; ch_mask = '0;
        en6 = 1; mode6 = 0; sel6 = 3'd7; mask6 = '0;
        for (int k = 0; k < CH; k++) din[k*W +: W] = W'(k + 3);
        for (int k = 0; k < CH6; k++) din6[k*W +: W] = W'(k + 3);
        modelReset();
        repeat (2) @(negedge clk);
        compareAll();
        rst_n = 1'b1;

        // Manual selection, including an out-of-range select on the 6-channel instance
        applyStimulus(1, 0, 3'd5, '0);
        checkOutput("man_dout", dout, 8);
        checkOutput("man_ch", dout_ch, 5);
        checkOutput("man_valid", dout_valid, 1);
        checkOutput("oor_dout", dout6, 0);
        checkOutput("oor_valid", valid6, 0);
        sel6 = 3'd4;
        applyStimulus(1, 0, 3'd6, '0);
        checkOutput("man_dout6", dout, 9);
        checkOutput("in_range6", dout6, 7);

        // Reset asserted between clock edges clears outputs at once
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_dout", dout, 0);
        checkOutput("arst_ch", dout_ch, 0);
        checkOutput("arst_valid", dout_valid, 0);
        checkOutput("arst_dout6", dout6, 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1, '0, 8'hA4);
            checkOutput("scan_ch", dout_ch, expCh[i]);
            checkOutput("scan_wrap", wrap, expWr[i]);
        end
        applyStimulus(1, 1, '0, 8'hA4);
        applyStimulus(1, 1, '0, 8'hA4);
        checkOutput("pre_drop_ch", dout_ch, 5);

        // Current channel disabled mid-dwell
        applyStimulus(1, 1, '0, 8'h84);
        checkOutput("drop_ch", dout_ch, 7);
        checkOutput("drop_wrap", wrap, 0);
        applyStimulus(1, 1, '0, 8'h84);
        checkOutput("drop_ch2", dout_ch, 7);
        applyStimulus(1, 1, '0, 8'h84);
        checkOutput("drop_ch3", dout_ch, 2);
        checkOutput("drop_wrap3", wrap, 1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, '0, '0);
            checkOutput("empty_valid", dout_valid, 0);
            checkOutput("empty_dout", dout, 0);
            checkOutput("empty_wrap", wrap, 0);
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1, '0, 8'h08);
            checkOutput("single_ch", dout_ch, 3);
            checkOutput("single_wrap", wrap, wr5[i]);
        end

        // Enable dropped exactly on dwell expiry
        applyStimulus(0, 1, '0, 8'hA4);
        applyStimulus(1, 1, '0, 8'hA4);
        applyStimulus(1, 1, '0, 8'hA4);
        applyStimulus(0, 1, '0, 8'hA4);
        checkOutput("idle_valid", dout_valid, 0);
        checkOutput("idle_wrap", wrap, 0);
        checkOutput("idle_ch", dout_ch, 2);
        checkOutput("idle_dout", dout, 5);
        applyStimulus(1, 1, '0, 8'hA4);
        checkOutput("restart_ch", dout_ch, 2);
        checkOutput("restart_valid", dout_valid, 1);
        applyStimulus(1, 1, '0, 8'hA4);
        checkOutput("restart_ch2", dout_ch, 2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ch_mask = '0;
                    1:       ch_mask = CH'(1) << $urandom_range(0, CH - 1);
                    default: ch_mask = CH'($urandom);
                endcase
            end
            sel   = SW'($urandom);
            din   = $urandom;
            sel6  = 3'($urandom);
            mask6 = CH6'($urandom);
            din6  = (CH6*W)'($urandom);
            cycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
